instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Multi-cycle fetch/decode controller for the 8-bit simple processor. Fetches instructions from
//  instruction memory over a req/rdy handshake and splits them into register addresses, raw
//  immediate fields (imm3/imm5, consumed by SignExt_3to8 / SignExt_5to8) and ALU control.
//  Sequences FETCH->DECODE->EXEC->WB, updates the PC, resolves branches and stops on HALT.
// PARAMETERS
//  RESET_PC     8'h00   PC value loaded on reset
//  ISA_W        8       instruction width (fixed encoding below; only 8 is supported)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  1-cycle pulse: leave IDLE and begin fetching at pc
//  imem_req     out  1  instruction fetch request, held until imem_rdy
//  imem_addr    out  8  fetch address (= pc)
//  imem_rdy     in   1  instr valid this cycle; accepted only while imem_req=1
//  instr        in   8  fetched instruction
//  rf_raddr_a   out  2  register-file read address A (rd)
//  rf_raddr_b   out  2  register-file read address B (rs)
//  imm3         out  3  raw 3-bit immediate to SignExt_3to8
//  imm5         out  5  raw 5-bit immediate to SignExt_5to8
//  alu_op       out  1  1=add, 0=subtract
//  alu_b_sel    out  1  0=ALU B from rf port B, 1=ALU B from sign-extended imm3
//  alu_zero     in   1  ALU result==0, sampled in EXEC
//  rf_we        out  1  register write enable (1-cycle pulse in WB)
//  rf_waddr     out  2  register write address
//  pc           out  8  program counter
//  halted       out  1  1 while in HALT state
//  busy         out  1  1 in any state except IDLE and HALT
// BEHAVIOUR
//  Encoding [7:6] op:
//   00 ALU  rd=[5:4] rs=[3:2] sub=[0]             rd <= rd op rs
//   01 ALUI rd=[5:4] sub=[3] imm3=[2:0]           rd <= rd op sext(imm3)
//   10 BR   cond=[5] imm5=[4:0]                   cond=0 always; cond=1 if alu_zero (last EXEC)
//   11 SYS  [5:0]==0 NOP, anything else HALT
//  Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, instruction reg=8'h00, every other output 0.
//  States: IDLE -start-> FETCH; FETCH -imem_rdy-> DECODE (latch instr); DECODE -> EXEC;
//   EXEC -> WB (ALU/ALUI) or FETCH (BR/NOP) or HALT (HALT); WB -> FETCH. HALT exits only on reset.
//  FETCH: imem_req=1, imem_addr=pc; req stays high until imem_rdy; no timeout.
//  DECODE/EXEC/WB: rf_raddr_a/b, imm3, imm5, alu_op(=~sub), alu_b_sel held stable from latched instr.
//  Zero flag: alu_zero registered at the end of EXEC of ALU/ALUI only; BR/NOP leave it unchanged; reset 0.
//  PC: ALU/ALUI/NOP: pc+1 at end of EXEC. BR taken: pc <= pc + 1 + sext(imm5), mod 256.
//   BR not taken: pc+1. HALT: pc unchanged. Wrap 8'hFF->8'h00 silently.
//  WB: rf_we=1 for exactly one cycle, rf_waddr=rd. No other state asserts rf_we.
//  Latency: ALU/ALUI = 4 cycles after imem_rdy-cycle incl. WB; BR/NOP = 2 cycles after DECODE entry.
//  start ignored outside IDLE. imem_rdy outside FETCH ignored. Reset mid-fetch drops request same cycle.
// TESTING
//  1 reset, start, mem returns 8'h49 (ALUI r0,+1... sub=1,imm3=001) -> imm3=001, alu_op=0, alu_b_sel=1,
//    one rf_we pulse with rf_waddr=0, pc 00->01.
//  2 imem_rdy delayed 5 cycles -> imem_req held, imem_addr=pc constant, no decode outputs change.
//  3 pc=8'h10, instr 8'h9C (BR always, imm5=11100=-4) -> pc=8'h0D; rf_we never asserted.
//  4 conditional BR 8'hA3 after ALU with alu_zero=0 -> pc+1; repeat with alu_zero=1 -> pc+1+3.
//  5 pc=8'hFF, NOP 8'hC0 -> pc=8'h00; instr 8'hC1 -> halted=1, busy=0, further start ignored.
//  6 drop rst_n during DECODE -> next edge-independent: state IDLE, pc=RESET_PC, all outputs 0.

Source files
------------

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory fetch port between the fetch/decode controller (master)
// and the instruction memory (slave).
interface instr_fetch_decode_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_rdy;
    logic [7:0] instr;

    // Handshake: imem_req rises with a stable imem_addr and holds until a cycle with
    // imem_rdy=1; that cycle transfers instr. imem_rdy is ignored while imem_req=0.
    modport master (output imem_req, output imem_addr, input imem_rdy, input instr);
    modport slave  (input imem_req, input imem_addr, output imem_rdy, output instr);
endinterface

// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode controller for the 8-bit processor:
// IDLE -> FETCH -> DECODE -> EXEC -> (WB) -> FETCH, stopping in HALT.
module instr_fetch_decode #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         ISA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    instr_fetch_decode_if.master        imem,
    output logic [1:0]                  rf_raddr_a,
    output logic [1:0]                  rf_raddr_b,
    output logic [2:0]                  imm3,
    output logic [4:0]                  imm5,
    output logic                        alu_op,
    output logic                        alu_b_sel,
    input  logic                        alu_zero,
    output logic                        rf_we,
    output logic [1:0]                  rf_waddr,
    output logic [7:0]                  pc,
    output logic                        halted,
    output logic                        busy,
    output logic [2:0]                  dbg_state
);

    if (ISA_W != 8) begin : g_isa_check
        $error("instr_fetch_decode supports only ISA_W = 8");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ALU  = 2'b00;
    localparam logic [1:0] OP_ALUI = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [ISA_W-1:0] instr_q, instr_d;
    logic             zero_q, zero_d;

    logic [1:0] op;
    logic [1:0] rd;
    logic [7:0] br_off;
    logic       br_taken;
    logic       dec_valid;

    assign op       = instr_q[7:6];
    assign rd       = instr_q[5:4];
    assign br_off   = {{3{instr_q[4]}}, instr_q[4:0]};
    // cond=0 branches always; cond=1 uses the flag left by the last ALU/ALUI EXEC.
    assign br_taken = !instr_q[5] || zero_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_rdy) begin
                    instr_d = imem.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_ALU, OP_ALUI: begin
                        zero_d  = alu_zero;
                        pc_d    = pc_q + 8'd1;
                        state_d = S_WB;
                    end
                    OP_BR: begin
                        pc_d    = br_taken ? (pc_q + 8'd1 + br_off) : (pc_q + 8'd1);
                        state_d = S_FETCH;
                    end
                    default: begin
                        if (instr_q[5:0] == 6'd0) begin
                            pc_d    = pc_q + 8'd1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                endcase
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Decode fields are only driven while an instruction is in flight; otherwise zero.
    always_comb begin
        dec_valid  = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB);
        rf_raddr_a = 2'b00;
        rf_raddr_b = 2'b00;
        imm3       = 3'b000;
        imm5       = 5'b00000;
        alu_op     = 1'b0;
        alu_b_sel  = 1'b0;
        if (dec_valid) begin
            case (op)
                OP_ALU: begin
                    rf_raddr_a = rd;
                    rf_raddr_b = instr_q[3:2];
                    alu_op     = ~instr_q[0];
                end
                OP_ALUI: begin
                    rf_raddr_a = rd;
                    imm3       = instr_q[2:0];
                    alu_op     = ~instr_q[3];
                    alu_b_sel  = 1'b1;
                end
                OP_BR:   imm5 = instr_q[4:0];
                default: ;
            endcase
        end
        rf_we          = (state_q == S_WB);
        rf_waddr       = (state_q == S_WB) ? rd : 2'b00;
        imem.imem_req  = (state_q == S_FETCH);
        imem.imem_addr = pc_q;
        pc             = pc_q;
        halted         = (state_q == S_HALT);
        busy           = (state_q != S_IDLE) && (state_q != S_HALT);
        dbg_state      = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: decode table, directed corner sequences
// and random programs checked against an instruction-level reference model.
module tb_instr_fetch_decode;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       alu_zero = 1'b0;
    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [2:0] imm3;
    logic [4:0] imm5;
    logic       alu_op, alu_b_sel, rf_we, halted, busy;
    logic [7:0] pc;
    logic [2:0] dbg_state;

    instr_fetch_decode_if imem_bus ();

    always #5 clk = ~clk;

    instr_fetch_decode #(.RESET_PC(8'h00), .ISA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem       (imem_bus),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .imm3       (imm3),
        .imm5       (imm5),
        .alu_op     (alu_op),
        .alu_b_sel  (alu_b_sel),
        .alu_zero   (alu_zero),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .pc         (pc),
        .halted     (halted),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- model / scoreboard ----------------
    typedef struct packed {
        logic [1:0] ra;
        logic [1:0] rb;
        logic [2:0] imm3;
        logic [4:0] imm5;
        logic       op;
        logic       bsel;
        logic       wb;
    } dec_t;

    typedef struct {
        logic [7:0] ins;
        logic       zin;
        dec_t       exp;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_pc;
    logic       m_zero;
    logic       m_halted;
    logic [1:0] exp_q[$];
    vec_t       vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t model_dec(input logic [7:0] i);
        dec_t d;
        d = '0;
        case (i[7:6])
            2'b00: begin d.ra = i[5:4]; d.rb = i[3:2]; d.op = ~i[0]; d.wb = 1'b1; end
            2'b01: begin d.ra = i[5:4]; d.imm3 = i[2:0]; d.op = ~i[3]; d.bsel = 1'b1; d.wb = 1'b1; end
            2'b10: d.imm5 = i[4:0];
            default: ;
        endcase
        return d;
    endfunction

    function automatic int sext5(input logic [4:0] v);
        int s;
        s = int'(v);
        if (s > 15) s -= 32;
        return s;
    endfunction

    // Architectural effect of one instruction on pc / zero flag / halt.
    task automatic step_model(input logic [7:0] ins, input logic zin);
        case (ins[7:6])
            2'b00, 2'b01: begin m_pc = (m_pc + 1) % 256; m_zero = zin; end
            2'b10: begin
                if (!ins[5] || m_zero) m_pc = (m_pc + 1 + sext5(ins[4:0]) + 256) % 256;
                else                   m_pc = (m_pc + 1) % 256;
            end
            default: begin
                if (ins[5:0] == 6'd0) m_pc = (m_pc + 1) % 256;
                else                  m_halted = 1'b1;
            end
        endcase
    endtask

    function automatic vec_t mkvec(input logic [7:0] ins, input logic zin, input logic [1:0] ra,
                                   input logic [1:0] rb, input logic [2:0] i3, input logic [4:0] i5,
                                   input logic op, input logic bsel, input logic wb);
        vec_t v;
        v.ins = ins; v.zin = zin;
        v.exp.ra = ra; v.exp.rb = rb; v.exp.imm3 = i3; v.exp.imm5 = i5;
        v.exp.op = op; v.exp.bsel = bsel; v.exp.wb = wb;
        return v;
    endfunction

    // Every register write must match the next queued destination.
    always @(negedge clk) begin
        if (rst_n && rf_we === 1'b1) begin
            if (exp_q.size() == 0) check("rf_we_unexpected", 32'(rf_we), 32'd0);
            else                   check("sb_rf_waddr", 32'(rf_waddr), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dec(input string tag, input dec_t e);
        check({tag, "_raddr_a"}, 32'(rf_raddr_a), 32'(e.ra));
        check({tag, "_raddr_b"}, 32'(rf_raddr_b), 32'(e.rb));
        check({tag, "_imm3"},    32'(imm3),       32'(e.imm3));
        check({tag, "_imm5"},    32'(imm5),       32'(e.imm5));
        check({tag, "_alu_op"},  32'(alu_op),     32'(e.op));
        check({tag, "_b_sel"},   32'(alu_b_sel),  32'(e.bsel));
    endtask

    task automatic check_reset_outputs(input string tag);
        dec_t z;
        z = '0;
        check({tag, "_req"},    32'(imem_bus.imem_req),  32'd0);
        check({tag, "_addr"},   32'(imem_bus.imem_addr), 32'h00);
        check({tag, "_pc"},     32'(pc),                 32'h00);
        check({tag, "_rf_we"},  32'(rf_we),              32'd0);
        check({tag, "_waddr"},  32'(rf_waddr),           32'd0);
        check({tag, "_halted"}, 32'(halted),             32'd0);
        check({tag, "_busy"},   32'(busy),               32'd0);
        check_dec(tag, z);
    endtask

    // Asserts reset immediately (asynchronously), checks outputs, then releases it.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        start = 1'b0;
        imem_bus.imem_rdy = 1'b0;
        #1;
        check_reset_outputs(tag);
        tick();
        tick();
        rst_n = 1'b1;
        m_pc = 0; m_zero = 1'b0; m_halted = 1'b0;
        exp_q.delete();
        tick();
        check({tag, "_idle_req"}, 32'(imem_bus.imem_req), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Serves one fetch (after dly wait cycles) and follows it through to the next FETCH.
    task automatic run_instr(input logic [7:0] ins, input int dly, input logic zin, input dec_t ed);
        int   waited;
        dec_t zd;
        zd = '0;
        waited = 0;
        while (imem_bus.imem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("fetch_req", 32'(imem_bus.imem_req), 32'd1);
        if (imem_bus.imem_req !== 1'b1) return;
        check("fetch_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
        check("fetch_busy", 32'(busy), 32'd1);
        for (int c = 0; c < dly; c++) begin
            imem_bus.imem_rdy = 1'b0;
            imem_bus.instr    = 8'($urandom);
            start             = 1'($urandom);
            tick();
            check("wait_req", 32'(imem_bus.imem_req), 32'd1);
            check("wait_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
            check_dec("wait", zd);
        end
        imem_bus.imem_rdy = 1'b1;
        imem_bus.instr    = ins;
        start             = 1'($urandom);
        tick();
        // DECODE: memory-side noise must be ignored from here on
        imem_bus.imem_rdy = 1'($urandom);
        imem_bus.instr    = 8'($urandom);
        start             = 1'b0;
        check("decode_req", 32'(imem_bus.imem_req), 32'd0);
        check_dec("decode", ed);
        if (ed.wb) exp_q.push_back(ins[5:4]);
        alu_zero = zin;
        tick();
        check_dec("exec", ed);
        check("exec_rf_we", 32'(rf_we), 32'd0);
        imem_bus.imem_rdy = 1'($urandom);
        step_model(ins, zin);
        tick();
        alu_zero = 1'($urandom);
        check("pc_after_exec", 32'(pc), 32'(m_pc));
        if (m_halted) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_busy", 32'(busy), 32'd0);
            check("halt_req", 32'(imem_bus.imem_req), 32'd0);
        end else if (ed.wb) begin
            check("wb_rf_we", 32'(rf_we), 32'd1);
            check("wb_rf_waddr", 32'(rf_waddr), 32'(ins[5:4]));
            check_dec("wb", ed);
            tick();
            check("after_wb_req", 32'(imem_bus.imem_req), 32'd1);
            check("after_wb_rf_we", 32'(rf_we), 32'd0);
        end else begin
            check("after_exec_req", 32'(imem_bus.imem_req), 32'd1);
        end
        imem_bus.imem_rdy = 1'b0;
    endtask

    task automatic run_model(input logic [7:0] ins, input int dly, input logic zin);
        run_instr(ins, dly, zin, model_dec(ins));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] ins;
        imem_bus.imem_rdy = 1'b0;
        imem_bus.instr    = 8'h00;

        //                ins    zin  ra    rb    imm3  imm5    op    bsel  wb
        vecs[0] = mkvec(8'h49, 1'b0, 2'd0, 2'd0, 3'd1, 5'h00, 1'b0, 1'b1, 1'b1);
        vecs[1] = mkvec(8'h1D, 1'b1, 2'd1, 2'd3, 3'd0, 5'h00, 1'b0, 1'b0, 1'b1);
        vecs[2] = mkvec(8'hC0, 1'b0, 2'd0, 2'd0, 3'd0, 5'h00, 1'b0, 1'b0, 1'b0);
        vecs[3] = mkvec(8'hA3, 1'b0, 2'd0, 2'd0, 3'd0, 5'h03, 1'b0, 1'b0, 1'b0);
        vecs[4] = mkvec(8'h2C, 1'b0, 2'd2, 2'd3, 3'd0, 5'h00, 1'b1, 1'b0, 1'b1);
        vecs[5] = mkvec(8'h76, 1'b1, 2'd3, 2'd0, 3'd6, 5'h00, 1'b1, 1'b1, 1'b1);
        vecs[6] = mkvec(8'h9C, 1'b0, 2'd0, 2'd0, 3'd0, 5'h1C, 1'b0, 1'b0, 1'b0);

        // Decode table, starting with the ALUI 8'h49 from reset (pc 00 -> 01).
        do_reset("rst0");
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            run_instr(vecs[i].ins, (i == 1) ? 5 : 0, vecs[i].zin, vecs[i].exp);
            if (i == 0) check("t1_pc_01", 32'(pc), 32'h01);
        end

        // Unconditional branch from pc 8'h10 backwards by 4.
        do_reset("rst_br");
        pulse_start();
        run_model(8'h8F, 0, 1'b0);
        check("t3_pc_10", 32'(pc), 32'h10);
        run_model(8'h9C, 2, 1'b1);
        check("t3_pc_0d", 32'(pc), 32'h0D);

        // Conditional branch sees the zero flag of the last ALU op, not of NOP/BR cycles.
        do_reset("rst_cbr");
        pulse_start();
        run_model(8'h00, 0, 1'b0);
        run_model(8'hA3, 0, 1'b1);
        check("t4_not_taken", 32'(pc), 32'h02);
        run_model(8'h00, 1, 1'b1);
        run_model(8'hC0, 0, 1'b0);
        run_model(8'hA3, 0, 1'b0);
        check("t4_taken", 32'(pc), 32'h08);

        // PC wrap on NOP at 8'hFF, then HALT ignores start.
        do_reset("rst_wrap");
        pulse_start();
        run_model(8'h90, 0, 1'b0);
        check("t5_pc_f1", 32'(pc), 32'hF1);
        run_model(8'h8D, 0, 1'b0);
        check("t5_pc_ff", 32'(pc), 32'hFF);
        run_model(8'hC0, 0, 1'b0);
        check("t5_pc_wrap", 32'(pc), 32'h00);
        run_model(8'hC1, 0, 1'b0);
        pulse_start();
        tick();
        tick();
        check("t5_halt_sticky", 32'(halted), 32'd1);
        check("t5_halt_busy", 32'(busy), 32'd0);
        check("t5_halt_req", 32'(imem_bus.imem_req), 32'd0);
        check("t5_halt_pc", 32'(pc), 32'h00);

        // Reset while a fetch request is pending drops it at once.
        do_reset("rst_pre_fetch");
        pulse_start();
        check("t6_req_up", 32'(imem_bus.imem_req), 32'd1);
        #2;
        do_reset("rst_mid_fetch");

        // Reset during DECODE clears every output.
        pulse_start();
        imem_bus.imem_rdy = 1'b1;
        imem_bus.instr    = 8'h76;
        tick();
        imem_bus.imem_rdy = 1'b0;
        check("t6_decode_b_sel", 32'(alu_b_sel), 32'd1);
        #2;
        do_reset("rst_mid_decode");

        // Random programs (HALT replaced by NOP until the final instruction).
        pulse_start();
        for (int n = 0; n < 150; n++) begin
            ins = 8'($urandom);
            if (ins[7:6] == 2'b11 && ins[5:0] != 6'd0 && $urandom_range(0, 3) != 0) ins = 8'hC0;
            if (ins[7:6] == 2'b11 && ins[5:0] != 6'd0) ins = 8'hC0;
            run_model(ins, $urandom_range(0, 3), 1'($urandom));
        end
        run_model(8'hFF, 1, 1'b0);
        tick();
        tick();
        check("final_wb_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_halted", 32'(halted), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
